ch_mux_seq: RTL and testbench

//  Parametrised successor to the fixed 8:1 channel mux. Snapshots NCH input channels on a

---
 rtl/ch_mux_seq_pkg.sv | 21 ++
 rtl/ch_mux_seq_bank.sv | 47 ++++
 rtl/ch_mux_seq.sv | 174 +++++++++++++++++
 tb/tb_ch_mux_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ch_mux_seq_pkg.sv
// Package: ch_mux_seq_pkg
// Shared definitions for the channel sequencer slice.
//   state_t      - sequencer FSM states (IDLE / SEND)
//   DEF_*        - default WIDTH / NCH / SEL_W
//   slice_lo()   - low bit of channel k inside the packed din bus
package ch_mux_seq_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_NCH   = 8;
    localparam int unsigned DEF_SEL_W = 3;

    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/ch_mux_seq_bank.sv
// Module: ch_mux_bank
// NCH x WIDTH snapshot register bank with a load enable and an indexed read.
//   clock    in   system clock
//   reset    in   synchronous active-high reset, clears every snapshot
//   load     in   capture all NCH channels of din this edge
//   din      in   NCH*WIDTH packed channels
//   rd_idx   in   SEL_W+1 bit read index
//   rd_data  out  snapshot at rd_idx, 0 for rd_idx >= NCH
module ch_mux_bank
    import ch_mux_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NCH   = DEF_NCH,
    parameter int unsigned SEL_W = DEF_SEL_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [NCH*WIDTH-1:0]   din,
    input  logic [SEL_W:0]         rd_idx,
    output logic [WIDTH-1:0]       rd_data
);

    logic [WIDTH-1:0] snap [NCH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                snap[k] <= '0;
            end
        end else if (load) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                snap[k] <= din[slice_lo(k, WIDTH) +: WIDTH];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (rd_idx == (SEL_W+1)'(k)) begin
                rd_data = snap[k];
            end
        end
    end

endmodule

// File: rtl/ch_mux_seq.sv
// Module: ch_mux_seq
// Snapshots NCH channels on a sample strobe and serialises the first nchan of
// them one per clock with a channel tag; a static mode keeps the legacy
// registered select mux.
//   clock, reset          clock and synchronous active-high reset
//   din                   NCH*WIDTH channels, channel k at din[k*WIDTH +: WIDTH]
//   strobe_in             one-cycle sample strobe
//   nchan                 active channel count, 0 or >NCH means NCH
//   mode_static, sel      1 = registered mux on sel, 0 = sequencer
//   clear_overrun         clears the sticky overrun flag
//   dout, dout_valid, dout_ch, dout_first, dout_last   registered output sample
//   busy                  burst in progress
//   overrun               sticky: strobe dropped during a burst
module ch_mux_seq
    import ch_mux_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NCH   = DEF_NCH,
    parameter int unsigned SEL_W = DEF_SEL_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NCH*WIDTH-1:0]   din,
    input  logic                   strobe_in,
    input  logic [SEL_W:0]         nchan,
    input  logic                   mode_static,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   clear_overrun,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_valid,
    output logic [SEL_W-1:0]       dout_ch,
    output logic                   dout_first,
    output logic                   dout_last,
    output logic                   busy,
    output logic                   overrun
);

    localparam logic [SEL_W:0] NCH_C = (SEL_W+1)'(NCH);
    localparam logic [SEL_W:0] ONE   = (SEL_W+1)'(1);

    state_t           state, state_nxt;
    logic [SEL_W:0]   idx, idx_nxt;
    logic [SEL_W:0]   n_lat, n_lat_nxt;
    logic [SEL_W:0]   n_eff;
    logic             load, start, emit, stat, ovr_set;
    logic [WIDTH-1:0] rd_data, static_data;

    logic [WIDTH-1:0] dout_n;
    logic             valid_n, first_n, last_n, busy_n;
    logic [SEL_W-1:0] ch_n;

    ch_mux_bank #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_bank (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .din     (din),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    always_comb begin
        if (nchan == '0 || nchan > NCH_C) begin
            n_eff = NCH_C;
        end else begin
            n_eff = nchan;
        end
    end

    always_comb begin
        static_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (sel == SEL_W'(k)) begin
                static_data = din[slice_lo(k, WIDTH) +: WIDTH];
            end
        end
    end

    // Channel 0 is registered straight from din on the accepting edge (the bank
    // loads on the same edge), which gives the one-cycle strobe-to-ch0 latency;
    // later channels come from the bank, so din changes cannot reach them.
    always_comb begin
        start     = 1'b0;
        emit      = 1'b0;
        stat      = 1'b0;
        ovr_set   = 1'b0;
        load      = 1'b0;
        idx_nxt   = idx;
        n_lat_nxt = n_lat;
        dout_n    = '0;
        valid_n   = 1'b0;
        ch_n      = '0;
        first_n   = 1'b0;
        last_n    = 1'b0;
        busy_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                stat  = mode_static;
                start = !mode_static && strobe_in;
            end
            ST_SEND: begin
                if (!dout_last) begin
                    emit    = 1'b1;
                    ovr_set = strobe_in;
                end else begin
                    start = !mode_static && strobe_in;
                    stat  = mode_static;
                end
            end
            default: ;
        endcase

        if (start) begin
            load      = 1'b1;
            n_lat_nxt = n_eff;
            idx_nxt   = ONE;
            dout_n    = din[WIDTH-1:0];
            valid_n   = 1'b1;
            first_n   = 1'b1;
            last_n    = (n_eff == ONE);
            busy_n    = 1'b1;
        end else if (emit) begin
            idx_nxt   = idx + 1'b1;
            dout_n    = rd_data;
            ch_n      = idx[SEL_W-1:0];
            valid_n   = 1'b1;
            last_n    = (idx == n_lat - 1'b1);
            busy_n    = 1'b1;
        end else if (stat) begin
            dout_n    = static_data;
            ch_n      = sel;
            valid_n   = strobe_in;
            first_n   = strobe_in;
            last_n    = strobe_in;
        end

        state_nxt = (start || emit) ? ST_SEND : ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            n_lat      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_ch    <= '0;
            dout_first <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            n_lat      <= n_lat_nxt;
            dout       <= dout_n;
            dout_valid <= valid_n;
            dout_ch    <= ch_n;
            dout_first <= first_n;
            dout_last  <= last_n;
            busy       <= busy_n;
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ch_mux_seq.sv
module tb_ch_mux_seq;

    localparam int W   = 16;
    localparam int NCH = 8;
    localparam int SW  = 3;

    logic            clock = 1'b0;
    logic            reset;
    logic [NCH*W-1:0] din;
    logic [6*W-1:0]  din6;
    logic            strobe_in;
    logic [SW:0]     nchan;
    logic            mode_static;
    logic [SW-1:0]   sel;
    logic            clear_overrun;

    logic [W-1:0]    dout,  dout6;
    logic            dout_valid, dout_valid6;
    logic [SW-1:0]   dout_ch, dout_ch6;
    logic            dout_first, dout_first6;
    logic            dout_last, dout_last6;
    logic            busy, busy6;
    logic            overrun, overrun6;

    always #5 clock = ~clock;

    ch_mux_seq #(.WIDTH(W), .NCH(NCH), .SEL_W(SW)) u_dut (
        .clock(clock), .reset(reset), .din(din), .strobe_in(strobe_in),
        .nchan(nchan), .mode_static(mode_static), .sel(sel),
        .clear_overrun(clear_overrun), .dout(dout), .dout_valid(dout_valid),
        .dout_ch(dout_ch), .dout_first(dout_first), .dout_last(dout_last),
        .busy(busy), .overrun(overrun)
    );

    ch_mux_seq #(.WIDTH(W), .NCH(6), .SEL_W(SW)) u_dut6 (
        .clock(clock), .reset(reset), .din(din6), .strobe_in(strobe_in),
        .nchan(nchan), .mode_static(mode_static), .sel(sel),
        .clear_overrun(clear_overrun), .dout(dout6), .dout_valid(dout_valid6),
        .dout_ch(dout_ch6), .dout_first(dout_first6), .dout_last(dout_last6),
        .busy(busy6), .overrun(overrun6)
    );

    int nchecks = 0;
    int nerr    = 0;

    // Reference model: a burst is a queue of pending output beats.
    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] ch;
        logic          f;
        logic          l;
    } item_t;

    item_t          q[$];
    logic [W-1:0]   e_dout;
    logic           e_valid, e_first, e_last, e_busy, e_ovr;
    logic [SW-1:0]  e_ch;

    function automatic logic [W-1:0] chan(input logic [NCH*W-1:0] d, input int k);
        return d[k*W +: W];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        item_t it;
        int    n;
        logic  set;
        set = 1'b0;
        if (reset) begin
            q.delete();
            e_dout = '0; e_valid = 0; e_ch = '0; e_first = 0; e_last = 0;
            e_busy = 0; e_ovr = 0;
        end else begin
            if (e_busy && !e_last) begin
                set = strobe_in;
                it  = q.pop_front();
                e_dout = it.d; e_ch = it.ch; e_first = it.f; e_last = it.l;
                e_valid = 1; e_busy = 1;
            end else if (!mode_static && strobe_in) begin
                n = (nchan == 0 || int'(nchan) > NCH) ? NCH : int'(nchan);
                q.delete();
                for (int k = 0; k < n; k++) begin
                    it.d = chan(din, k); it.ch = SW'(k);
                    it.f = (k == 0); it.l = (k == n - 1);
                    q.push_back(it);
                end
                it = q.pop_front();
                e_dout = it.d; e_ch = it.ch; e_first = it.f; e_last = it.l;
                e_valid = 1; e_busy = 1;
            end else if (mode_static) begin
                e_dout  = (int'(sel) < NCH) ? chan(din, int'(sel)) : '0;
                e_ch    = sel;
                e_valid = strobe_in; e_first = strobe_in; e_last = strobe_in;
                e_busy  = 0;
            end else begin
                e_dout = '0; e_valid = 0; e_ch = '0; e_first = 0; e_last = 0;
                e_busy = 0;
            end
            if (set) e_ovr = 1;
            else if (clear_overrun) e_ovr = 0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_dout"},  32'(dout),       32'(e_dout));
        chk({tag, "_valid"}, 32'(dout_valid), 32'(e_valid));
        chk({tag, "_ch"},    32'(dout_ch),    32'(e_ch));
        chk({tag, "_first"}, 32'(dout_first), 32'(e_first));
        chk({tag, "_last"},  32'(dout_last),  32'(e_last));
        chk({tag, "_busy"},  32'(busy),       32'(e_busy));
        chk({tag, "_ovr"},   32'(overrun),    32'(e_ovr));
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic set_din_default();
        for (int k = 0; k < NCH; k++) din[k*W +: W] = W'(16'h1000 + k);
        for (int k = 0; k < 6; k++) din6[k*W +: W] = W'(16'h1000 + k);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"},  32'(dout), 0);
        chk({tag, "_valid"}, 32'(dout_valid), 0);
        chk({tag, "_ch"},    32'(dout_ch), 0);
        chk({tag, "_fl"},    32'({dout_first, dout_last}), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_ovr"},   32'(overrun), 0);
    endtask

    initial begin
        reset = 1; strobe_in = 0; nchan = 4'd4; mode_static = 0; sel = '0;
        clear_overrun = 0;
        set_din_default();
        e_dout = '0; e_valid = 0; e_ch = '0; e_first = 0; e_last = 0;
        e_busy = 0; e_ovr = 0;

        // 1: reset held 3 cycles with activity on the inputs
        for (int i = 0; i < 3; i++) begin
            strobe_in = i[0]; mode_static = i[1] | i[0];
            cycle("t1_rst");
            chk_zero("t1_rst_c");
        end
        reset = 0; strobe_in = 0; mode_static = 0;
        cycle("t1_rel");
        chk_zero("t1_rel_c");

        // 2: four-channel burst
        nchan = 4'd4; strobe_in = 1;
        for (int k = 0; k < 4; k++) begin
            cycle("t2");
            strobe_in = 0;
            chk("t2_dout", 32'(dout), 32'h1000 + k);
            chk("t2_ch", 32'(dout_ch), k);
            chk("t2_fl", 32'({dout_first, dout_last, busy}), {k == 0, k == 3, 1'b1});
        end
        cycle("t2_idle");
        chk("t2_idle", 32'({dout_valid, busy}), 0);

        // 3: dropped strobe sets overrun, strobe on last beat is gapless
        strobe_in = 1;
        cycle("t3_c0");
        strobe_in = 0;
        cycle("t3_c1");
        strobe_in = 1;
        cycle("t3_c2");
        chk("t3_ovr_set", 32'(overrun), 1);
        chk("t3_c2_dout", 32'(dout), 32'h1002);
        strobe_in = 0;
        cycle("t3_c3");
        chk("t3_c3_last", 32'(dout_last), 1);
        strobe_in = 1;
        cycle("t3_gapless");
        chk("t3_gapless", 32'({dout_first, dout_ch, dout}), {1'b1, 3'd0, 16'h1000});
        strobe_in = 0;
        for (int i = 0; i < 3; i++) cycle("t3_tail");
        chk("t3_ovr_hold", 32'(overrun), 1);
        clear_overrun = 1;
        cycle("t3_clr");
        clear_overrun = 0;
        chk("t3_ovr_clr", 32'(overrun), 0);

        // 4: nchan=0 means all eight; din changes after snapshot are ignored
        nchan = 4'd0; strobe_in = 1;
        cycle("t4");
        strobe_in = 0;
        chk("t4_c0", 32'(dout), 32'h1000);
        for (int k = 0; k < NCH; k++) din[k*W +: W] = 16'hBEEF;
        for (int k = 1; k < NCH; k++) begin
            cycle("t4");
            chk("t4_dout", 32'(dout), 32'h1000 + k);
            chk("t4_last", 32'(dout_last), 32'(k == NCH - 1));
        end
        set_din_default();
        cycle("t4_idle");

        // 5: static mode
        mode_static = 1; sel = 3'd5; strobe_in = 1;
        cycle("t5_s5");
        chk("t5_s5", 32'({dout_valid, dout_ch, dout}), {1'b1, 3'd5, 16'h1005});
        chk("t5_s5_6", 32'({dout_valid6, dout_ch6, dout6, busy6}), {1'b1, 3'd5, 16'h1005, 1'b0});
        sel = 3'd7; strobe_in = 0;
        cycle("t5_s7");
        chk("t5_s7", 32'({dout_valid, dout_ch, dout}), {1'b0, 3'd7, 16'h1007});
        chk("t5_s7_6", 32'({dout_valid6, dout_first6, dout_last6, dout_ch6, dout6}),
            {3'b000, 3'd7, 16'h0000});
        strobe_in = 1;
        cycle("t5_s7b");
        chk("t5_s7b_6", 32'({dout_valid6, dout_first6, dout_last6, busy6, overrun6, dout6}),
            {5'b11100, 16'h0000});
        chk("t5_busy", 32'(busy), 0);
        strobe_in = 0; mode_static = 0;
        cycle("t5_end");

        // 6: reset mid-burst, then restart
        nchan = 4'd4; strobe_in = 1;
        cycle("t6_c0");
        strobe_in = 0;
        cycle("t6_c1");
        reset = 1;
        cycle("t6_rst");
        chk_zero("t6_rst_c");
        reset = 0; strobe_in = 1;
        cycle("t6_re");
        chk("t6_restart", 32'({dout_first, dout_ch, dout}), {1'b1, 3'd0, 16'h1000});
        strobe_in = 0;
        for (int i = 0; i < 4; i++) cycle("t6_tail");

        // N=1 with a strobe every cycle
        nchan = 4'd1; strobe_in = 1;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < NCH; k++) din[k*W +: W] = W'($urandom);
            cycle("n1");
            chk("n1_fl", 32'({dout_first, dout_last, dout_valid}), 3'b111);
        end
        strobe_in = 0;
        cycle("n1_end");

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < NCH; k++) din[k*W +: W] = W'($urandom);
            for (int k = 0; k < 6; k++) din6[k*W +: W] = W'($urandom);
            strobe_in     = ($urandom_range(0, 2) == 0);
            nchan         = 4'($urandom_range(0, 15));
            sel           = 3'($urandom_range(0, 7));
            clear_overrun = ($urandom_range(0, 9) == 0);
            reset         = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) mode_static = ~mode_static;
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
